sevenseg_sched: RTL and testbench

Display scheduler and scan controller for the 8-digit multiplexed seven-segment panel. It shares the panel between four requesters: source 0 is the error/alarm source with preemptive priority; sources 1-3 are register, status and debug views served round-robin. It also sequences the digit scan with inter-digit blanking and PWM brightness. All display changes are frame-atomic: grant, data and brightness change only at frame boundaries.

---
 rtl/sevenseg_pkg.sv | 48 ++++
 rtl/sevenseg_rr_arb.sv | 63 ++++++
 rtl/sevenseg_sched.sv | 123 ++++++++++++
 tb/tb_sevenseg_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package sevenseg_pkg;

    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned SRC_IDX_W  = 2;

    // Segment codes, bit 0 = a ... bit 6 = g, active-high
    localparam logic [SEG_W-1:0] SSEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SSEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SSEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SSEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SSEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SSEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SSEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SSEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SSEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SSEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SSEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SSEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SSEG_BLANK = 7'h00;

    typedef struct packed {
        logic             dot;
        logic [SEG_W-1:0] seg;
    } digit_t;

    typedef digit_t [NUM_DIGITS-1:0] frame_t;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

    // Unpack a source's flat segment/dot vectors into a frame
    function automatic frame_t pack_frame(input logic [NUM_DIGITS*SEG_W-1:0] segs,
                                          input logic [NUM_DIGITS-1:0]       dots);
        frame_t f;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            f[d].seg = segs[d*SEG_W +: SEG_W];
            f[d].dot = dots[d];
        end
        return f;
    endfunction

endpackage

// File: rtl/sevenseg_rr_arb.sv
// Frame-boundary arbitration: source 0 preempts, sources 1-3 share round-robin with dwell.
module sevenseg_rr_arb
    import sevenseg_pkg::*;
#(
    parameter int unsigned DWELL_FRAMES = 64,
    parameter int unsigned DWELL_W      = 6
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [NUM_SRC-1:0]   gnt_q,
    input  logic [DWELL_W-1:0]   dwell_q,
    input  logic [SRC_IDX_W-1:0] ptr_q,
    output logic [NUM_SRC-1:0]   gnt_c,
    output logic [DWELL_W-1:0]   dwell_c,
    output logic [SRC_IDX_W-1:0] ptr_c
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    logic                 found;
    logic [SRC_IDX_W-1:0] sel;
    logic [SRC_IDX_W-1:0] cand;

    // k-th source after pointer p, cycling through 1..3
    function automatic logic [SRC_IDX_W-1:0] rr_cand(input logic [SRC_IDX_W-1:0] p,
                                                      input logic [SRC_IDX_W-1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s > 3'd3) s = s - 3'd3;
        return s[SRC_IDX_W-1:0];
    endfunction

    // Priority, dwell and round-robin search for the next frame's grant
    always_comb begin
        gnt_c   = '0;
        dwell_c = dwell_q;
        ptr_c   = ptr_q;
        found   = 1'b0;
        sel     = '0;
        cand    = '0;
        if (req[0]) begin
            gnt_c = NUM_SRC'(1);
        end else if ((gnt_q[3:1] != 3'b000) && ((req & gnt_q) != '0) &&
                     (dwell_q < DWELL_LAST)) begin
            gnt_c   = gnt_q;
            dwell_c = dwell_q + DWELL_W'(1);
        end else begin
            for (int k = 1; k <= 3; k++) begin
                cand = rr_cand(ptr_q, SRC_IDX_W'(k));
                if (!found && req[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
            if (found) begin
                gnt_c = NUM_SRC'(1) << sel;
                ptr_c = sel;
                // a sole requester re-wins with its dwell left saturated
                dwell_c = gnt_q[sel] ? dwell_q : '0;
            end
        end
    end

endmodule

// File: rtl/sevenseg_sched.sv
// Seven-segment panel scheduler: frame-atomic arbitration plus digit scan with blanking and PWM.
module sevenseg_sched
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS  = 8192,
    parameter int unsigned BLANK_TICKS  = 256,
    parameter int unsigned DWELL_FRAMES = 64
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_SRC-1:0]                        req,
    input  logic [NUM_SRC-1:0][NUM_DIGITS*SEG_W-1:0]  src_seg,
    input  logic [NUM_SRC-1:0][NUM_DIGITS-1:0]        src_dots,
    input  logic [2:0]                                bright,
    output logic [NUM_SRC-1:0]                        gnt,
    output logic [NUM_DIGITS-1:0]                     dig,
    output logic [7:0]                                seg,
    output logic                                      frame_tick
);

    localparam int unsigned TICK_W  = $clog2(DIGIT_TICKS);
    localparam int unsigned DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX   = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);

    scan_state_t          state_q, state_n;
    logic [TICK_W-1:0]    tick_q, tick_n;
    logic [ADDR_W-1:0]    addr_q, addr_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_c;
    logic [SRC_IDX_W-1:0] ptr_q, ptr_c;
    logic [NUM_SRC-1:0]   gnt_c;
    frame_t               buf_q, buf_n;
    logic [2:0]           bright_q, bright_n;
    logic                 boundary;
    logic [7:0]           dig_d, seg_d;
    logic                 frame_tick_d;

    sevenseg_rr_arb #(
        .DWELL_FRAMES (DWELL_FRAMES),
        .DWELL_W      (DWELL_W)
    ) u_arb (
        .req     (req),
        .gnt_q   (gnt),
        .dwell_q (dwell_q),
        .ptr_q   (ptr_q),
        .gnt_c   (gnt_c),
        .dwell_c (dwell_c),
        .ptr_c   (ptr_c)
    );

    // Scan state, counters, arbitration state and frame buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SCAN_BLANK;
            tick_q   <= '0;
            addr_q   <= '0;
            dwell_q  <= '0;
            ptr_q    <= SRC_IDX_W'(3);
            gnt      <= '0;
            buf_q    <= '0;
            bright_q <= 3'd7;
        end else begin
            state_q  <= state_n;
            tick_q   <= tick_n;
            addr_q   <= addr_n;
            buf_q    <= buf_n;
            bright_q <= bright_n;
            if (boundary) begin
                gnt     <= gnt_c;
                dwell_q <= dwell_c;
                ptr_q   <= ptr_c;
            end
        end
    end

    // Next scan state, counters and frame-boundary latching
    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q + TICK_W'(1);
        addr_n   = addr_q;
        buf_n    = buf_q;
        bright_n = bright_q;
        boundary = (addr_q == 3'd7) && (tick_q == TICK_MAX);
        if (tick_q == TICK_MAX) addr_n = addr_q + ADDR_W'(1);
        case (state_q)
            SCAN_BLANK: if (tick_q == BLANK_LAST) state_n = SCAN_ON;
            SCAN_ON:    if (tick_q == TICK_MAX)   state_n = SCAN_BLANK;
            default:    state_n = SCAN_BLANK;
        endcase
        if (boundary) begin
            bright_n = bright;
            buf_n    = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (gnt_c[s]) buf_n = pack_frame(src_seg[s], src_dots[s]);
            end
        end
    end

    // Drive outputs from the next state so registered pins line up with the scan
    always_comb begin
        dig_d        = 8'hFF;
        seg_d        = 8'hFF;
        frame_tick_d = (addr_n == 3'd7) && (tick_n == TICK_MAX);
        if (state_n == SCAN_ON) begin
            seg_d = ~8'(buf_n[addr_n]);
            if (tick_n[2:0] <= bright_n) dig_d = ~(8'b1 << addr_n);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig        <= 8'hFF;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            dig        <= dig_d;
            seg        <= seg_d;
            frame_tick <= frame_tick_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_sched.sv
// Randomized bench for sevenseg_sched against a frame-level reference model.
module tb_sevenseg_sched;

    localparam int DT = 16;
    localparam int BT = 4;
    localparam int DW = 2;
    localparam int FRAME = DT * 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0][55:0] src_seg;
    logic [3:0][7:0]  src_dots;
    logic [2:0]       bright;
    logic [3:0]       gnt;
    logic [7:0]       dig;
    logic [7:0]       seg;
    logic             frame_tick;

    sevenseg_sched #(
        .DIGIT_TICKS  (DT),
        .BLANK_TICKS  (BT),
        .DWELL_FRAMES (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .src_seg    (src_seg),
        .src_dots   (src_dots),
        .bright     (bright),
        .gnt        (gnt),
        .dig        (dig),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    int         m_gnt;
    int         m_dwell;
    int         m_ptr;
    int         m_bright;
    logic [55:0] m_seg;
    logic [7:0]  m_dots;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1; m_dwell = 0; m_ptr = 3; m_bright = 7;
        m_seg = '0; m_dots = '0; cyc = 0;
    endtask

    // Frame-boundary decision from the arbitration rules, using inputs seen at that edge
    task automatic model_boundary();
        int c;
        bit hit;
        if (req[0]) begin
            m_gnt = 0;
        end else if (m_gnt >= 1 && req[m_gnt] && m_dwell < DW - 1) begin
            m_dwell++;
        end else begin
            hit = 0;
            for (int k = 1; k <= 3; k++) begin
                c = ((m_ptr - 1 + k) % 3) + 1;
                if (!hit && req[c]) begin
                    hit = 1;
                    if (c != m_gnt) m_dwell = 0;
                    m_gnt = c;
                    m_ptr = c;
                end
            end
            if (!hit) m_gnt = -1;
        end
        m_bright = int'(bright);
        if (m_gnt < 0) begin
            m_seg = '0; m_dots = '0;
        end else begin
            m_seg = src_seg[m_gnt]; m_dots = src_dots[m_gnt];
        end
    endtask

    // One clock: advance model across the edge, then check outputs mid-cycle
    task automatic step();
        int p, t, a;
        logic [7:0] e_dig, e_seg;
        logic [3:0] e_gnt;
        @(posedge clk);
        if (cyc % FRAME == FRAME - 1) model_boundary();
        cyc++;
        @(negedge clk);
        p = cyc % FRAME; t = p % DT; a = p / DT;
        e_dig = 8'hFF; e_seg = 8'hFF;
        if (t >= BT) begin
            e_seg = ~{m_dots[a], m_seg[a*7 +: 7]};
            if ((t % 8) <= m_bright) e_dig = ~(8'(1) << a);
        end
        e_gnt = (m_gnt < 0) ? 4'h0 : 4'(1 << m_gnt);
        chk("dig", 32'(dig), 32'(e_dig));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("frame_tick", 32'(frame_tick), 32'(p == FRAME - 1));
    endtask

    task automatic rand_data();
        for (int s = 0; s < 4; s++) begin
            src_seg[s]  = 56'({$urandom(), $urandom()});
            src_dots[s] = 8'($urandom());
        end
    endtask

    task automatic run(input int n, input bit churn);
        for (int i = 0; i < n; i++) begin
            if (churn && $urandom_range(0, 15) == 0) rand_data();
            step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dig", 32'(dig), 32'hFF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ftick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        rst_n = 1'b1; req = '0; bright = 3'd7;
        src_seg = '0; src_dots = '0;
        model_reset();
        do_reset();

        // idle scan, panel dark
        run(FRAME + 10, 0);

        // single source with a known pattern on digit 0
        rand_data();
        src_seg[1][6:0] = 7'h3F; src_dots[1][0] = 1'b1;
        req = 4'b0010;
        run(2 * FRAME, 0);

        // round-robin among 1-3 with data changing mid-frame
        req = 4'b1110;
        run(7 * FRAME, 1);

        // preempt source 2 mid-frame, then release
        guard = 0;
        while (m_gnt != 2 && guard < 4 * FRAME) begin
            step();
            guard++;
        end
        chk("wait_gnt2", 32'(m_gnt == 2), 32'd1);
        run(40, 0);
        req = 4'b1111;
        run(2 * FRAME, 1);
        req = 4'b1110;
        run(2 * FRAME, 1);

        // brightness, including minimum, changed mid-frame
        bright = 3'd0;
        run(2 * FRAME, 0);
        bright = 3'd3;
        run(FRAME + 37, 0);

        // random traffic
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                if ($urandom_range(0, 99) == 0) req = 4'($urandom());
                if ($urandom_range(0, 199) == 0) bright = 3'($urandom());
                if ($urandom_range(0, 15) == 0) rand_data();
                step();
            end
        end

        // async reset mid-frame while digit 2 is lit for source 1
        req = 4'b0010; bright = 3'd7;
        run(3 * FRAME, 0);
        guard = 0;
        while ((cyc % FRAME) != 2 * DT + 6 && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        chk("pre_rst_dig", 32'(dig), 32'hFB);
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dig", 32'(dig), 32'hFF);
        chk("async_seg", 32'(seg), 32'hFF);
        chk("async_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(3 * FRAME, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
